fetch_unit: RTL and testbench

- Instruction-fetch stage of the rv32i core.
- Owns the PC register and issues one word request at a time to instruction memory over a req/gnt + rvalid handshake.
- Hands each returned instruction to decode over a valid/ready interface.
- Accepts redirects (branch/jump targets) from execute and discards any in-flight stale fetch.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared rv32i definitions used by the fetch stage: widths, the NOP used to
// fill the instruction buffer on reset, the default reset PC and the fetch
// state encoding.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // REQ  : presenting a request to instruction memory
  // WAIT : request granted, waiting for the response
  // DROP : request granted but a redirect arrived; swallow the response
  // HOLD : instruction buffered and offered to decode
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Clear the byte offset of a redirect target so fetches stay word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's two handshakes: the instruction-memory
// req/gnt + rvalid channel and the valid/ready channel towards decode.
// The master modport is the fetch unit's view; slave is the environment
// (instruction memory plus decode).
interface fetch_unit_if #(
  parameter int XLEN = rv32_pkg::XLEN
) ();

  // instruction memory channel
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  // decode channel
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );

endinterface

// File: rtl/fetch_unit.sv
// rv32i instruction-fetch stage. Owns the PC, issues one word fetch at a
// time, buffers the returned instruction for decode and follows redirects
// from execute, discarding any response that belongs to a stale fetch.
module fetch_unit #(
  parameter int                XLEN     = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = rv32_pkg::DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  fetch_unit_if.master     bus,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             fetch_misalign
);

  import rv32_pkg::*;

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   pc_next;
  logic [ILEN-1:0]   buf_reg;
  logic [ILEN-1:0]   buf_next;
  logic [XLEN-1:0]   pend_reg;
  logic [XLEN-1:0]   pend_next;
  logic              misalign_reg;
  logic [XLEN-1:0]   redirect_tgt;
  logic [XLEN-1:0]   pc_plus4;

  assign redirect_tgt = align_word(redirect_pc);
  assign pc_plus4     = pc_reg + XLEN'(4);

  // Interface outputs are decoded straight from the current state. A redirect
  // in HOLD withdraws the offered instruction in the same cycle.
  assign bus.imem_req   = (state_reg == REQ);
  assign bus.imem_addr  = pc_reg;
  assign bus.if_valid   = (state_reg == HOLD) && !redirect_valid;
  assign bus.if_pc      = pc_reg;
  assign bus.if_instr   = buf_reg;
  assign fetch_misalign = misalign_reg;

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, next-PC, buffer and pending-target selection.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    buf_next   = buf_reg;
    pend_next  = pend_reg;

    unique case (state_reg)
      REQ: begin
        // A redirect before the grant simply retargets the request; the
        // address is allowed to change while the request is ungranted.
        if (redirect_valid) begin
          pc_next = redirect_tgt;
        end else if (bus.imem_gnt) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (bus.imem_rvalid && redirect_valid) begin
          pc_next    = redirect_tgt;
          state_next = REQ;
        end else if (bus.imem_rvalid) begin
          buf_next   = bus.imem_rdata;
          state_next = HOLD;
        end else if (redirect_valid) begin
          // The fetch is already accepted by memory, so its response must
          // still be absorbed before the new target can be requested.
          pend_next  = redirect_tgt;
          state_next = DROP;
        end
      end

      DROP: begin
        if (bus.imem_rvalid) begin
          // The youngest redirect wins when it coincides with the response.
          pc_next    = redirect_valid ? redirect_tgt : pend_reg;
          state_next = REQ;
        end else if (redirect_valid) begin
          pend_next = redirect_tgt;
        end
      end

      HOLD: begin
        // Redirect beats if_ready: the offered instruction is on the wrong
        // path and must not be consumed.
        if (redirect_valid) begin
          pc_next    = redirect_tgt;
          state_next = REQ;
        end else if (bus.if_ready) begin
          pc_next    = pc_plus4;
          state_next = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase
  end

  // PC register; coded inline because it resets to RESET_PC rather than 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Instruction buffer and pending redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg  <= NOP_INSTR;
      pend_reg <= '0;
    end else begin
      buf_reg  <= buf_next;
      pend_reg <= pend_next;
    end
  end

  // Flag a redirect whose target was not word aligned, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Two instances share all stimulus: u_dut0
// with the default reset PC and u_dut1 with RESET_PC = 0x1000. A small
// instruction-memory model grants whenever enabled and returns data a
// programmable number of cycles after the grant.
module tb_fetch_unit;

  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt_en;
  int          rv_delay;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic        ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic        mis0;
  logic        mis1;

  int          rv_cnt = 0;
  logic [31:0] lat0 = '0;
  logic [31:0] lat1 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus0 ();
  fetch_unit_if #(.XLEN(32)) bus1 ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign bus0.imem_gnt    = gnt_en & bus0.imem_req;
  assign bus1.imem_gnt    = gnt_en & bus1.imem_req;
  assign bus0.imem_rvalid = (rv_cnt == 1);
  assign bus1.imem_rvalid = (rv_cnt == 1);
  assign bus0.imem_rdata  = ovr_en ? ovr_data : mem_word(lat0);
  assign bus1.imem_rdata  = ovr_en ? ovr_data : mem_word(lat1);
  assign bus0.if_ready    = ready;
  assign bus1.if_ready    = ready;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus0),
    .redirect_valid (rd_valid),
    .redirect_pc    (rd_pc),
    .fetch_misalign (mis0)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_1000)) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus1),
    .redirect_valid (rd_valid),
    .redirect_pc    (rd_pc),
    .fetch_misalign (mis1)
  );

  // Memory model: remember the granted address, answer rv_delay cycles later.
  always @(posedge clk) begin
    if (rst) begin
      rv_cnt <= 0;
    end else if (bus0.imem_req && bus0.imem_gnt) begin
      rv_cnt <= rv_delay;
      lat0   <= bus0.imem_addr;
      lat1   <= bus1.imem_addr;
    end else if (rv_cnt != 0) begin
      rv_cnt <= rv_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // A response may only arrive while a fetch is outstanding.
  always @(negedge clk) begin
    if (!rst && bus0.imem_rvalid) begin
      check_val("rvalid_state",
                {31'b0, (u_dut0.state_reg == WAIT) || (u_dut0.state_reg == DROP)}, 32'd1);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    gnt_en   = 1'b1;
    rv_delay = 1;
    ovr_en   = 1'b0;
    ovr_data = '0;
    ready    = 1'b0;
    rd_valid = 1'b0;
    rd_pc    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    rst      = 1'b1;
    gnt_en   = 1'b1;
    rv_delay = 1;
    ovr_en   = 1'b0;
    ovr_data = '0;
    ready    = 1'b0;
    rd_valid = 1'b0;
    rd_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req",   {31'b0, bus0.imem_req}, 32'd1);
    check_val("rst_addr0", bus0.imem_addr, 32'h0000_0000);
    check_val("rst_addr1", bus1.imem_addr, 32'h0000_1000);
    check_val("rst_valid", {31'b0, bus0.if_valid}, 32'd0);
    check_val("rst_instr", bus0.if_instr, 32'h0000_0013);
    check_val("rst_mis",   {31'b0, mis0}, 32'd0);
    rst = 1'b0;

    // Streaming: fetch every 3 cycles, if_valid on cycles 2,5,8,11
    ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      check_val("s1_req",   {31'b0, bus0.imem_req}, {31'b0, (c % 3) == 0});
      check_val("s1_valid", {31'b0, bus0.if_valid}, {31'b0, (c % 3) == 2});
      check_val("s1_addr",  bus0.imem_addr, 32'(4 * (c / 3)));
      if ((c % 3) == 2) begin
        check_val("s1_pc",    bus0.if_pc, 32'(4 * (c / 3)));
        check_val("s1_instr", bus0.if_instr, mem_word(32'(4 * (c / 3))));
      end
      next_cyc();
    end

    // Decode stalls 5 cycles at the first HOLD of the RESET_PC=0x1000 core
    do_reset();
    next_cyc();
    next_cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("s2_valid", {31'b0, bus1.if_valid}, 32'd1);
      check_val("s2_pc",    bus1.if_pc, 32'h0000_1000);
      check_val("s2_instr", bus1.if_instr, mem_word(32'h0000_1000));
      check_val("s2_noreq", {31'b0, bus1.imem_req}, 32'd0);
      next_cyc();
    end
    ready = 1'b1;
    #1;
    check_val("s2_valid_rdy", {31'b0, bus1.if_valid}, 32'd1);
    next_cyc();
    #1;
    check_val("s2_req",  {31'b0, bus1.imem_req}, 32'd1);
    check_val("s2_addr", bus1.imem_addr, 32'h0000_1004);

    // Redirect in WAIT to 0x200; the late 0xDEADBEEF response is dropped
    do_reset();
    rv_delay = 3;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    ready    = 1'b1;
    next_cyc();
    rd_valid = 1'b1;
    rd_pc    = 32'h0000_0200;
    #1;
    check_val("s3_valid_w", {31'b0, bus0.if_valid}, 32'd0);
    next_cyc();
    rd_valid = 1'b0;
    next_cyc();
    #1;
    check_val("s3_rvalid", {31'b0, bus0.imem_rvalid}, 32'd1);
    check_val("s3_valid_d", {31'b0, bus0.if_valid}, 32'd0);
    next_cyc();
    rv_delay = 1;
    ovr_en   = 1'b0;
    #1;
    check_val("s3_req",  {31'b0, bus0.imem_req}, 32'd1);
    check_val("s3_addr", bus0.imem_addr, 32'h0000_0200);
    next_cyc();
    next_cyc();
    #1;
    check_val("s3_valid", {31'b0, bus0.if_valid}, 32'd1);
    check_val("s3_pc",    bus0.if_pc, 32'h0000_0200);
    check_val("s3_instr", bus0.if_instr, mem_word(32'h0000_0200));

    // Redirects in DROP: 0x300, then 0x400 together with rvalid
    do_reset();
    rv_delay = 3;
    next_cyc();
    rd_valid = 1'b1;
    rd_pc    = 32'h0000_0100;
    next_cyc();
    rd_pc = 32'h0000_0300;
    next_cyc();
    rd_pc = 32'h0000_0400;
    #1;
    check_val("s4_rvalid", {31'b0, bus0.imem_rvalid}, 32'd1);
    next_cyc();
    rd_valid = 1'b0;
    rv_delay = 1;
    #1;
    check_val("s4_req",  {31'b0, bus0.imem_req}, 32'd1);
    check_val("s4_addr", bus0.imem_addr, 32'h0000_0400);

    // Misaligned redirect in HOLD with if_ready=1
    do_reset();
    ready = 1'b1;
    next_cyc();
    next_cyc();
    rd_valid = 1'b1;
    rd_pc    = 32'h0000_0106;
    #1;
    check_val("s5_valid", {31'b0, bus0.if_valid}, 32'd0);
    check_val("s5_mis0",  {31'b0, mis0}, 32'd0);
    next_cyc();
    rd_valid = 1'b0;
    #1;
    check_val("s5_req",  {31'b0, bus0.imem_req}, 32'd1);
    check_val("s5_addr", bus0.imem_addr, 32'h0000_0104);
    check_val("s5_mis1", {31'b0, mis0}, 32'd1);
    next_cyc();
    #1;
    check_val("s5_mis2", {31'b0, mis0}, 32'd0);

    // PC wrap at 0xFFFFFFFC, then reset while in WAIT
    do_reset();
    ready    = 1'b1;
    gnt_en   = 1'b0;
    rd_valid = 1'b1;
    rd_pc    = 32'hFFFF_FFFC;
    next_cyc();
    gnt_en   = 1'b1;
    rd_valid = 1'b0;
    #1;
    check_val("s6_addr_top", bus0.imem_addr, 32'hFFFF_FFFC);
    check_val("s6_mis",      {31'b0, mis0}, 32'd0);
    next_cyc();
    next_cyc();
    #1;
    check_val("s6_valid", {31'b0, bus0.if_valid}, 32'd1);
    check_val("s6_pc",    bus0.if_pc, 32'hFFFF_FFFC);
    next_cyc();
    #1;
    check_val("s6_req_wrap",  {31'b0, bus0.imem_req}, 32'd1);
    check_val("s6_addr_wrap", bus0.imem_addr, 32'h0000_0000);
    next_cyc();
    rst = 1'b1;
    #1;
    check_val("s6_in_wait", {31'b0, bus0.imem_req}, 32'd0);
    next_cyc();
    rst = 1'b0;
    #1;
    check_val("s6_rst_req",   {31'b0, bus1.imem_req}, 32'd1);
    check_val("s6_rst_addr1", bus1.imem_addr, 32'h0000_1000);
    check_val("s6_rst_addr0", bus0.imem_addr, 32'h0000_0000);
    check_val("s6_rst_valid", {31'b0, bus1.if_valid}, 32'd0);
    check_val("s6_rst_instr", bus1.if_instr, 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
